// File: rtl/mem_port_arbiter_if.sv
// Bundle of pipeline-side request/response and bus-side handshake signals.
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic                  longest_stall;

   logic                  inst_req;
   logic [ADDR_W-1:0]     inst_addr;
   logic [DATA_W-1:0]     inst_rdata;
   logic                  i_stall;

   logic                  data_req;
   logic                  data_wr;
   logic [DATA_W/8-1:0]   data_wstrb;
   logic [ADDR_W-1:0]     data_addr;
   logic [DATA_W-1:0]     data_wdata;
   logic [DATA_W-1:0]     data_rdata;
   logic                  d_stall;

   logic                  bus_req;
   logic                  bus_wr;
   logic [DATA_W/8-1:0]   bus_wstrb;
   logic [ADDR_W-1:0]     bus_addr;
   logic [DATA_W-1:0]     bus_wdata;
   logic                  bus_addr_ok;
   logic                  bus_data_ok;
   logic [DATA_W-1:0]     bus_rdata;

   // Arbiter view
   modport master (
      input  longest_stall,
      input  inst_req, inst_addr,
      output inst_rdata, i_stall,
      input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
      output data_rdata, d_stall,
      output bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
      input  bus_addr_ok, bus_data_ok, bus_rdata
   );

   // Datapath + bus bridge view
   modport slave (
      output longest_stall,
      output inst_req, inst_addr,
      input  inst_rdata, i_stall,
      output data_req, data_wr, data_wstrb, data_addr, data_wdata,
      input  data_rdata, d_stall,
      input  bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
      output bus_addr_ok, bus_data_ok, bus_rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like bus port between instruction fetch and data access.
// Data side has fixed priority; one transaction outstanding at a time.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   mem_port_arbiter_if.master    port
);
   localparam int unsigned STRB_W = DATA_W / 8;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_D_ADDR = 3'd1;
   localparam logic [2:0] S_D_DATA = 3'd2;
   localparam logic [2:0] S_I_ADDR = 3'd3;
   localparam logic [2:0] S_I_DATA = 3'd4;

   logic [2:0]          state_q,      state_d;
   logic                i_done_q,     i_done_d;
   logic                d_done_q,     d_done_d;
   logic                bus_req_q,    bus_req_d;
   logic                bus_wr_q,     bus_wr_d;
   logic [STRB_W-1:0]   bus_wstrb_q,  bus_wstrb_d;
   logic [ADDR_W-1:0]   bus_addr_q,   bus_addr_d;
   logic [DATA_W-1:0]   bus_wdata_q,  bus_wdata_d;
   logic [DATA_W-1:0]   inst_rdata_q, inst_rdata_d;
   logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;

   logic                set_i;
   logic                set_d;
   logic                arb;

   // Next-state, bus field and done-flag logic
   always_comb begin
      state_d      = state_q;
      i_done_d     = i_done_q;
      d_done_d     = d_done_q;
      bus_req_d    = bus_req_q;
      bus_wr_d     = bus_wr_q;
      bus_wstrb_d  = bus_wstrb_q;
      bus_addr_d   = bus_addr_q;
      bus_wdata_d  = bus_wdata_q;
      inst_rdata_d = inst_rdata_q;
      data_rdata_d = data_rdata_q;
      arb          = 1'b0;

      // Responses only count in the matching DATA state; stale ones are dropped
      set_i = (state_q == S_I_DATA) && port.bus_data_ok;
      set_d = (state_q == S_D_DATA) && port.bus_data_ok;

      case (state_q)
         S_IDLE: arb = 1'b1;
         S_D_ADDR: begin
            if (port.bus_addr_ok) begin
               state_d   = S_D_DATA;
               bus_req_d = 1'b0;
            end
         end
         S_I_ADDR: begin
            if (port.bus_addr_ok) begin
               state_d   = S_I_DATA;
               bus_req_d = 1'b0;
            end
         end
         S_D_DATA: begin
            if (port.bus_data_ok) begin
               if (!bus_wr_q) data_rdata_d = port.bus_rdata;
               arb = 1'b1;
            end
         end
         S_I_DATA: begin
            if (port.bus_data_ok) begin
               inst_rdata_d = port.bus_rdata;
               arb = 1'b1;
            end
         end
         default: begin
            state_d   = S_IDLE;
            bus_req_d = 1'b0;
         end
      endcase

      // Arbitration sees done flags including this cycle's completion
      if (arb) begin
         if (port.data_req && !(d_done_q || set_d)) begin
            state_d     = S_D_ADDR;
            bus_req_d   = 1'b1;
            bus_wr_d    = port.data_wr;
            bus_wstrb_d = port.data_wr ? port.data_wstrb : STRB_W'(0);
            bus_addr_d  = port.data_addr;
            bus_wdata_d = port.data_wdata;
         end else if (port.inst_req && !(i_done_q || set_i)) begin
            state_d     = S_I_ADDR;
            bus_req_d   = 1'b1;
            bus_wr_d    = 1'b0;
            bus_wstrb_d = STRB_W'(0);
            bus_addr_d  = port.inst_addr;
            bus_wdata_d = DATA_W'(0);
         end else begin
            state_d   = S_IDLE;
            bus_req_d = 1'b0;
         end
      end

      // Completion wins over a pipeline advance in the same cycle
      if (set_i)                    i_done_d = 1'b1;
      else if (!port.longest_stall) i_done_d = 1'b0;
      if (set_d)                    d_done_d = 1'b1;
      else if (!port.longest_stall) d_done_d = 1'b0;
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         i_done_q     <= 1'b0;
         d_done_q     <= 1'b0;
         bus_req_q    <= 1'b0;
         bus_wr_q     <= 1'b0;
         bus_wstrb_q  <= '0;
         bus_addr_q   <= '0;
         bus_wdata_q  <= '0;
         inst_rdata_q <= '0;
         data_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         i_done_q     <= i_done_d;
         d_done_q     <= d_done_d;
         bus_req_q    <= bus_req_d;
         bus_wr_q     <= bus_wr_d;
         bus_wstrb_q  <= bus_wstrb_d;
         bus_addr_q   <= bus_addr_d;
         bus_wdata_q  <= bus_wdata_d;
         inst_rdata_q <= inst_rdata_d;
         data_rdata_q <= data_rdata_d;
      end
   end

   assign port.bus_req    = bus_req_q;
   assign port.bus_wr     = bus_wr_q;
   assign port.bus_wstrb  = bus_wstrb_q;
   assign port.bus_addr   = bus_addr_q;
   assign port.bus_wdata  = bus_wdata_q;
   assign port.inst_rdata = inst_rdata_q;
   assign port.data_rdata = data_rdata_q;

   // Stalls are combinational so the hazard unit sees requests immediately
   assign port.i_stall = port.inst_req & ~i_done_q;
   assign port.d_stall = port.data_req & ~d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed vector bench for mem_port_arbiter.
module tb_mem_port_arbiter;
   localparam logic [31:0] IA  = 32'hBFC0_0000;
   localparam logic [31:0] IA4 = 32'hBFC0_0004;
   localparam logic [31:0] DA  = 32'h8000_0010;
   localparam logic [31:0] SA  = 32'h8000_0020;
   localparam logic [31:0] RA  = 32'h8000_0030;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_fail;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bif ();

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk  (clk),
      .rst  (rst),
      .port (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        ir;
      logic        dr;
      logic [31:0] iaddr;
      logic        aok;
      logic        dok;
      logic [31:0] rdata;
      logic        ls;
      logic        e_breq;
      logic [31:0] e_baddr;
      logic        e_is;
      logic        e_ds;
      logic [31:0] e_irdata;
      logic [31:0] e_drdata;
   } vec_t;

   vec_t tbl [18];

   function automatic vec_t mk(input logic ir, input logic dr, input logic [31:0] iaddr,
                               input logic aok, input logic dok, input logic [31:0] rdata,
                               input logic ls, input logic e_breq, input logic [31:0] e_baddr,
                               input logic e_is, input logic e_ds,
                               input logic [31:0] e_irdata, input logic [31:0] e_drdata);
      vec_t v;
      v.ir = ir; v.dr = dr; v.iaddr = iaddr; v.aok = aok; v.dok = dok;
      v.rdata = rdata; v.ls = ls; v.e_breq = e_breq; v.e_baddr = e_baddr;
      v.e_is = e_is; v.e_ds = e_ds; v.e_irdata = e_irdata; v.e_drdata = e_drdata;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Apply one cycle of inputs at the falling edge; outputs settle #1 later
   task automatic apply(input logic ir, input logic dr, input logic dwr, input logic [3:0] strb,
                        input logic [31:0] iaddr, input logic [31:0] daddr,
                        input logic [31:0] wdata, input logic aok, input logic dok,
                        input logic [31:0] rdata, input logic ls);
      @(negedge clk);
      bif.inst_req      = ir;
      bif.data_req      = dr;
      bif.data_wr       = dwr;
      bif.data_wstrb    = strb;
      bif.inst_addr     = iaddr;
      bif.data_addr     = daddr;
      bif.data_wdata    = wdata;
      bif.bus_addr_ok   = aok;
      bif.bus_data_ok   = dok;
      bif.bus_rdata     = rdata;
      bif.longest_stall = ls;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      n_cmp  = 0;
      n_fail = 0;

      // Fetch, then concurrent fetch+load, long stall hold, next fetch issue
      tbl[0]  = mk(1, 0, IA,  0, 0, 32'h0,         1, 0, 32'h0, 1, 1'b0, 32'h0,         32'h0);
      tbl[1]  = mk(1, 0, IA,  1, 0, 32'h0,         1, 1, IA,    1, 0, 32'h0,         32'h0);
      tbl[2]  = mk(1, 0, IA,  0, 1, 32'h2401_0001, 1, 0, IA,    1, 0, 32'h0,         32'h0);
      tbl[3]  = mk(1, 0, IA,  0, 0, 32'h0,         1, 0, IA,    0, 0, 32'h2401_0001, 32'h0);
      tbl[4]  = mk(1, 1, IA,  0, 0, 32'h0,         0, 0, IA,    0, 1, 32'h2401_0001, 32'h0);
      tbl[5]  = mk(1, 1, IA,  1, 0, 32'h0,         1, 1, DA,    1, 1, 32'h2401_0001, 32'h0);
      tbl[6]  = mk(1, 1, IA,  0, 1, 32'hDEAD_BEEF, 1, 0, DA,    1, 1, 32'h2401_0001, 32'h0);
      tbl[7]  = mk(1, 1, IA,  1, 0, 32'h0,         1, 1, IA,    1, 0, 32'h2401_0001, 32'hDEAD_BEEF);
      tbl[8]  = mk(1, 1, IA,  0, 1, 32'h8C22_0004, 1, 0, IA,    1, 0, 32'h2401_0001, 32'hDEAD_BEEF);
      tbl[9]  = mk(1, 1, IA,  0, 0, 32'h0,         1, 0, IA,    0, 0, 32'h8C22_0004, 32'hDEAD_BEEF);
      tbl[10] = mk(1, 1, IA,  1, 0, 32'h0,         1, 0, IA,    0, 0, 32'h8C22_0004, 32'hDEAD_BEEF);
      tbl[11] = mk(1, 1, IA,  0, 1, 32'hFFFF_FFFF, 1, 0, IA,    0, 0, 32'h8C22_0004, 32'hDEAD_BEEF);
      tbl[12] = mk(1, 0, IA,  0, 0, 32'h0,         0, 0, IA,    0, 0, 32'h8C22_0004, 32'hDEAD_BEEF);
      tbl[13] = mk(1, 0, IA4, 0, 0, 32'h0,         1, 0, IA,    1, 0, 32'h8C22_0004, 32'hDEAD_BEEF);
      tbl[14] = mk(1, 0, IA4, 0, 1, 32'hFFFF_FFFF, 1, 1, IA4,   1, 0, 32'h8C22_0004, 32'hDEAD_BEEF);
      tbl[15] = mk(1, 0, IA4, 1, 0, 32'h0,         1, 1, IA4,   1, 0, 32'h8C22_0004, 32'hDEAD_BEEF);
      tbl[16] = mk(1, 0, IA4, 0, 1, 32'h1111_2222, 1, 0, IA4,   1, 0, 32'h8C22_0004, 32'hDEAD_BEEF);
      tbl[17] = mk(1, 0, IA4, 0, 0, 32'h0,         1, 0, IA4,   0, 0, 32'h1111_2222, 32'hDEAD_BEEF);

      // Reset values
      rst = 1'b0;
      bif.inst_req = 0; bif.data_req = 0; bif.data_wr = 0; bif.data_wstrb = '0;
      bif.inst_addr = '0; bif.data_addr = '0; bif.data_wdata = '0;
      bif.bus_addr_ok = 0; bif.bus_data_ok = 0; bif.bus_rdata = '0; bif.longest_stall = 1;
      @(negedge clk); #1;
      chk("rst bus_req",    32'(bif.bus_req),   32'h0);
      chk("rst bus_wr",     32'(bif.bus_wr),    32'h0);
      chk("rst bus_wstrb",  32'(bif.bus_wstrb), 32'h0);
      chk("rst bus_addr",   bif.bus_addr,       32'h0);
      chk("rst bus_wdata",  bif.bus_wdata,      32'h0);
      chk("rst inst_rdata", bif.inst_rdata,     32'h0);
      chk("rst data_rdata", bif.data_rdata,     32'h0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 18; i++) begin
         apply(tbl[i].ir, tbl[i].dr, 1'b0, 4'h0, tbl[i].iaddr, DA, 32'h0,
               tbl[i].aok, tbl[i].dok, tbl[i].rdata, tbl[i].ls);
         chk($sformatf("v%0d bus_req", i),    32'(bif.bus_req), 32'(tbl[i].e_breq));
         chk($sformatf("v%0d bus_addr", i),   bif.bus_addr,     tbl[i].e_baddr);
         chk($sformatf("v%0d i_stall", i),    32'(bif.i_stall), 32'(tbl[i].e_is));
         chk($sformatf("v%0d d_stall", i),    32'(bif.d_stall), 32'(tbl[i].e_ds));
         chk($sformatf("v%0d inst_rdata", i), bif.inst_rdata,   tbl[i].e_irdata);
         chk($sformatf("v%0d data_rdata", i), bif.data_rdata,   tbl[i].e_drdata);
      end

      // Store with addr_ok delayed four cycles: request fields held stable
      apply(0, 1, 1, 4'b0011, IA4, SA, 32'h1234_ABCD, 0, 0, 32'h0, 1);
      chk("st issue d_stall", 32'(bif.d_stall), 32'h1);
      chk("st issue bus_req", 32'(bif.bus_req), 32'h0);
      for (int c = 1; c <= 5; c++) begin
         apply(0, 1, 1, 4'b0011, IA4, SA, (c == 2) ? 32'h0 : 32'h1234_ABCD,
               (c == 5) ? 1'b1 : 1'b0, 0, 32'h0, 1);
         chk($sformatf("st%0d bus_req", c),   32'(bif.bus_req),   32'h1);
         chk($sformatf("st%0d bus_wr", c),    32'(bif.bus_wr),    32'h1);
         chk($sformatf("st%0d bus_wstrb", c), 32'(bif.bus_wstrb), 32'h3);
         chk($sformatf("st%0d bus_addr", c),  bif.bus_addr,       SA);
         chk($sformatf("st%0d bus_wdata", c), bif.bus_wdata,      32'h1234_ABCD);
      end
      apply(0, 1, 1, 4'b0011, IA4, SA, 32'h1234_ABCD, 0, 1, 32'h5555_5555, 1);
      chk("st data bus_req", 32'(bif.bus_req), 32'h0);
      chk("st data d_stall", 32'(bif.d_stall), 32'h1);
      apply(0, 1, 1, 4'b0011, IA4, SA, 32'h1234_ABCD, 0, 0, 32'h0, 1);
      chk("st done d_stall",    32'(bif.d_stall), 32'h0);
      chk("st done data_rdata", bif.data_rdata,   32'hDEAD_BEEF);
      chk("st done bus_req",    32'(bif.bus_req), 32'h0);

      // Reset in D_DATA, then a stray response after release
      apply(0, 1, 0, 4'h0, IA4, RA, 32'h0, 0, 0, 32'h0, 0);
      apply(0, 1, 0, 4'h0, IA4, RA, 32'h0, 0, 0, 32'h0, 1);
      chk("rs pre d_stall", 32'(bif.d_stall), 32'h1);
      apply(0, 1, 0, 4'h0, IA4, RA, 32'h0, 1, 0, 32'h0, 1);
      chk("rs addr bus_req",  32'(bif.bus_req), 32'h1);
      chk("rs addr bus_addr", bif.bus_addr,     RA);
      apply(0, 1, 0, 4'h0, IA4, RA, 32'h0, 0, 0, 32'h0, 1);
      chk("rs data bus_req", 32'(bif.bus_req), 32'h0);
      #1;
      rst = 1'b0;
      bif.inst_req = 0;
      bif.data_req = 0;
      #1;
      chk("rs async bus_req",    32'(bif.bus_req),   32'h0);
      chk("rs async bus_wr",     32'(bif.bus_wr),    32'h0);
      chk("rs async bus_addr",   bif.bus_addr,       32'h0);
      chk("rs async bus_wstrb",  32'(bif.bus_wstrb), 32'h0);
      chk("rs async bus_wdata",  bif.bus_wdata,      32'h0);
      chk("rs async inst_rdata", bif.inst_rdata,     32'h0);
      chk("rs async data_rdata", bif.data_rdata,     32'h0);
      chk("rs async d_stall",    32'(bif.d_stall),   32'h0);
      @(negedge clk);
      rst = 1'b1;
      apply(0, 0, 0, 4'h0, IA4, RA, 32'h0, 0, 1, 32'h7777_7777, 1);
      chk("rs stray bus_req", 32'(bif.bus_req), 32'h0);
      apply(0, 1, 0, 4'h0, IA4, RA, 32'h0, 0, 0, 32'h0, 1);
      chk("rs stray d_stall",    32'(bif.d_stall), 32'h1);
      chk("rs stray data_rdata", bif.data_rdata,   32'h0);
      chk("rs stray bus_req2",   32'(bif.bus_req), 32'h0);
      apply(0, 1, 0, 4'h0, IA4, RA, 32'h0, 0, 0, 32'h0, 1);
      chk("rs reissue bus_req",  32'(bif.bus_req), 32'h1);
      chk("rs reissue bus_addr", bif.bus_addr,     RA);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
